// File: rtl/obstacle_ctrl.sv
// Scrolls one obstacle across the playfield per frame tick, detects collisions with
// the jumping player, and runs the idle/run/over game FSM with a saturating score.
module obstacle_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int PLAYER_X  = 100,
  parameter int PLAYER_W  = 20,
  parameter int OBS_W     = 20,
  parameter int OBS_H     = 40,
  parameter int SPEED     = 4,
  parameter int SCORE_MAX = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic [9:0]  jump_h,
  output logic [9:0]  obs_x,
  output logic [13:0] score,
  output logic        playing,
  output logic        game_over,
  output logic        collide
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t state;

  localparam logic [10:0] PLAYER_R = 11'(PLAYER_X + PLAYER_W);
  localparam logic [10:0] PLAYER_L = 11'(PLAYER_X);
  localparam logic [10:0] OBS_W_11 = 11'(OBS_W);
  localparam logic [9:0]  OBS_H_10 = 10'(OBS_H);
  localparam logic [9:0]  SPAWN_X  = 10'(SCREEN_W);
  localparam logic [9:0]  SPEED_10 = 10'(SPEED);
  localparam logic [13:0] SCORE_TOP = 14'(SCORE_MAX);

  // 11-bit compare so obs_x + OBS_W cannot wrap near the right edge.
  logic [10:0] obs_x_11;
  logic        overlap;

  always_comb begin
    obs_x_11 = {1'b0, obs_x};
    overlap  = (obs_x_11 < PLAYER_R) &&
               ((obs_x_11 + OBS_W_11) > PLAYER_L) &&
               (jump_h < OBS_H_10);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      obs_x     <= SPAWN_X;
      score     <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      collide   <= 1'b0;
    end else begin
      collide <= 1'b0;
      case (state)
        IDLE: begin
          obs_x <= SPAWN_X;
          score <= '0;
          if (start) begin
            state     <= RUN;
            playing   <= 1'b1;
            game_over <= 1'b0;
          end
        end
        RUN: begin
          if (tick) begin
            // Collision takes priority over the wrap, so no point is scored on it.
            if (overlap) begin
              state     <= OVER;
              playing   <= 1'b0;
              game_over <= 1'b1;
              collide   <= 1'b1;
            end else if (obs_x < SPEED_10) begin
              obs_x <= SPAWN_X;
              if (score < SCORE_TOP) score <= score + 14'd1;
            end else begin
              obs_x <= obs_x - SPEED_10;
            end
          end
        end
        OVER: begin
          if (start) begin
            state     <= RUN;
            obs_x     <= SPAWN_X;
            score     <= '0;
            playing   <= 1'b1;
            game_over <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          obs_x     <= SPAWN_X;
          score     <= '0;
          playing   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_ctrl.sv
// Directed game scenarios followed by randomized play, each cycle checked against
// a behavioural model of the game rules.
module tb_obstacle_ctrl;

  localparam int SCREEN_W  = 640;
  localparam int PLAYER_X  = 100;
  localparam int PLAYER_W  = 20;
  localparam int OBS_W     = 20;
  localparam int OBS_H     = 40;
  localparam int SPEED     = 4;
  localparam int SCORE_MAX = 9999;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        start;
  logic [9:0]  jump_h;
  logic [9:0]  obs_x;
  logic [13:0] score;
  logic        playing;
  logic        game_over;
  logic        collide;

  int checks   = 0;
  int failures = 0;

  obstacle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .jump_h    (jump_h),
    .obs_x     (obs_x),
    .score     (score),
    .playing   (playing),
    .game_over (game_over),
    .collide   (collide)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: game phase as a name, positions and score as plain integers
  string m_phase = "idle";
  int    m_x     = SCREEN_W;
  int    m_score = 0;
  bit    m_hit   = 1'b0;

  function automatic void model_step(bit rs, bit st, bit tk, int jh);
    bit hit;
    m_hit = 1'b0;
    if (rs) begin
      m_phase = "idle"; m_x = SCREEN_W; m_score = 0;
    end else if (m_phase == "idle") begin
      m_x = SCREEN_W; m_score = 0;
      if (st) m_phase = "run";
    end else if (m_phase == "run") begin
      if (tk) begin
        hit = (m_x < PLAYER_X + PLAYER_W) && (m_x + OBS_W > PLAYER_X) && (jh < OBS_H);
        if (hit) begin
          m_phase = "over"; m_hit = 1'b1;
        end else if (m_x < SPEED) begin
          m_x = SCREEN_W;
          m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
        end else begin
          m_x = m_x - SPEED;
        end
      end
    end else if (st) begin
      m_phase = "run"; m_x = SCREEN_W; m_score = 0;
    end
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all();
    chk("obs_x", 32'(obs_x), 32'(m_x));
    chk("score", 32'(score), 32'(m_score));
    chk("playing", 32'(playing), 32'(m_phase == "run"));
    chk("game_over", 32'(game_over), 32'(m_phase == "over"));
    chk("collide", 32'(collide), 32'(m_hit));
  endtask

  // driver tasks
  task automatic cycle(input bit rs, input bit st, input bit tk, input int jh);
    @(negedge clk);
    reset = rs; start = st; tick = tk; jump_h = 10'(jh);
    @(posedge clk);
    model_step(rs, st, tk, jh);
    #1;
    check_all();
  endtask

  // one tick followed by a quiet cycle with jump_h scrambled
  task automatic do_tick(input int jh);
    cycle(1'b0, 1'b0, 1'b1, jh);
    cycle(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 1023)));
  endtask

  task automatic do_ticks(input int n, input int jh);
    for (int i = 0; i < n; i++) do_tick(jh);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0; jump_h = '0;

    // reset held two cycles
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    chk("reset_obs_x", 32'(obs_x), 32'd640);
    chk("reset_score", 32'(score), 32'd0);
    chk("reset_collide", 32'(collide), 32'd0);

    // ticks in idle are ignored
    do_ticks(3, 0);
    chk("idle_tick_obs_x", 32'(obs_x), 32'd640);

    // start with tick in the same cycle: transition only
    cycle(1'b0, 1'b1, 1'b1, 0);
    chk("start_tick_playing", 32'(playing), 32'd1);
    chk("start_tick_obs_x", 32'(obs_x), 32'd640);
    do_ticks(10, 0);
    chk("ten_ticks_obs_x", 32'(obs_x), 32'd600);
    chk("ten_ticks_score", 32'(score), 32'd0);

    // grounded player gets hit at obs_x 116
    do_ticks(121, 0);
    chk("tick131_obs_x", 32'(obs_x), 32'd116);
    cycle(1'b0, 1'b0, 1'b1, 0);
    chk("tick132_collide", 32'(collide), 32'd1);
    chk("tick132_game_over", 32'(game_over), 32'd1);
    chk("tick132_obs_x", 32'(obs_x), 32'd116);
    do_ticks(5, 0);
    chk("over_collide_drop", 32'(collide), 32'd0);
    chk("over_hold_obs_x", 32'(obs_x), 32'd116);

    // restart from over, clear an obstacle with a high jump
    cycle(1'b0, 1'b1, 1'b0, 0);
    do_ticks(160, 50);
    chk("tick160_obs_x", 32'(obs_x), 32'd0);
    do_tick(50);
    chk("tick161_obs_x", 32'(obs_x), 32'd640);
    chk("tick161_score", 32'(score), 32'd1);

    // exactly OBS_H clears for two more laps, then one pixel short collides
    do_ticks(2 * 161, 40);
    chk("boundary40_score", 32'(score), 32'd3);
    chk("boundary40_playing", 32'(playing), 32'd1);
    do_ticks(131, 39);
    chk("boundary39_obs_x", 32'(obs_x), 32'd116);
    cycle(1'b0, 1'b0, 1'b1, 39);
    chk("boundary39_collide", 32'(collide), 32'd1);
    chk("boundary39_score", 32'(score), 32'd3);

    // restart from over with score 3
    cycle(1'b0, 1'b1, 1'b0, 0);
    chk("restart_playing", 32'(playing), 32'd1);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_obs_x", 32'(obs_x), 32'd640);

    // start is ignored while running; reset mid-run
    cycle(1'b0, 1'b1, 1'b1, 0);
    do_ticks(59, 0);
    chk("midrun_obs_x", 32'(obs_x), 32'd400);
    cycle(1'b1, 1'b1, 1'b1, 0);
    chk("midrun_reset_obs_x", 32'(obs_x), 32'd640);
    chk("midrun_reset_playing", 32'(playing), 32'd0);

    // randomized play
    for (int i = 0; i < 4000; i++) begin
      bit rs;
      bit st;
      bit tk;
      int jh;
      rs = ($urandom_range(0, 499) == 0);
      st = ($urandom_range(0, 39) == 0);
      tk = 1'($urandom_range(0, 1));
      jh = ($urandom_range(0, 1) == 1) ? int'($urandom_range(30, 50)) : int'($urandom_range(0, 1023));
      cycle(rs, st, tk, jh);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
